// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a data port onto one
// shared single-port memory. One access is in flight at a time. Data wins
// ties, but a fetch that has lost STARVE_LIMIT tied arbitrations in a row is
// forced through. All outputs are registered.
//
// Handshake: a requester raises x_req with a stable payload and holds it until
// x_ready pulses for one cycle; x_rdata is valid from that cycle onward. On the
// memory side mem_req and its payload stay constant from the cycle after the
// grant until the cycle in which mem_ack=1, and mem_rdata is taken in that
// same cycle.
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_ready,
    output logic [XLEN-1:0]  if_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [3:0]       d_amp,
    input  logic [31:0]      d_addr,
    input  logic [XLEN-1:0]  d_wdata,
    output logic             d_ready,
    output logic [XLEN-1:0]  d_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [3:0]       mem_amp,
    output logic [31:0]      mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic             mem_ack,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [1:0]       o_dbg_state,
    output logic [CNT_W-1:0] o_dbg_starve_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_grant_if;
    logic             w_grant_d;
    logic             w_if_done;
    logic             w_d_done;
    logic             w_if_elig;
    logic             w_d_elig;

    logic             r_if_ready;
    logic [XLEN-1:0]  r_if_rdata;
    logic             r_d_ready;
    logic [XLEN-1:0]  r_d_rdata;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [3:0]       r_mem_amp;
    logic [31:0]      r_mem_addr;
    logic [XLEN-1:0]  r_mem_wdata;
    logic [CNT_W-1:0] r_starve_cnt;

    // A request whose ready pulse is up right now is the one just finished,
    // not a new one, so it must not be granted again.
    assign w_if_elig = if_req && !r_if_ready;
    assign w_d_elig  = d_req && !r_d_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: arbitration in IDLE, wait for mem_ack while busy.
    always_comb begin
        w_next_state = r_state;
        w_grant_if   = 1'b0;
        w_grant_d    = 1'b0;
        w_if_done    = 1'b0;
        w_d_done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_d_elig && w_if_elig) begin
                    if (r_starve_cnt == LIMIT_C) begin
                        w_grant_if = 1'b1;
                    end else begin
                        w_grant_d = 1'b1;
                    end
                end else if (w_d_elig) begin
                    w_grant_d = 1'b1;
                end else if (w_if_elig) begin
                    w_grant_if = 1'b1;
                end
                if (w_grant_if) begin
                    w_next_state = BUSY_IF;
                end else if (w_grant_d) begin
                    w_next_state = BUSY_D;
                end
            end
            BUSY_IF: begin
                if (mem_ack) begin
                    w_if_done    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    w_d_done     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Memory request/payload registers and per-port completion outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_amp   <= 4'b0000;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= '0;
            r_if_ready  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_ready   <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            if (w_grant_if) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_amp   <= 4'b0000;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
            end else if (w_grant_d) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= d_we;
                r_mem_amp   <= d_amp;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
            end
            if (w_if_done) begin
                r_mem_req  <= 1'b0;
                r_if_ready <= 1'b1;
                r_if_rdata <= mem_rdata;
            end
            if (w_d_done) begin
                r_mem_req <= 1'b0;
                r_d_ready <= 1'b1;
                // A store completes without disturbing the last load result.
                if (!r_mem_we) begin
                    r_d_rdata <= mem_rdata;
                end
            end
        end
    end

    // Count data grants taken while a fetch was also asking; saturates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (w_grant_if) begin
            r_starve_cnt <= '0;
        end else if (w_grant_d) begin
            if (!if_req) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != LIMIT_C) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

    assign if_ready         = r_if_ready;
    assign if_rdata         = r_if_rdata;
    assign d_ready          = r_d_ready;
    assign d_rdata          = r_d_rdata;
    assign mem_req          = r_mem_req;
    assign mem_we           = r_mem_we;
    assign mem_amp          = r_mem_amp;
    assign mem_addr         = r_mem_addr;
    assign mem_wdata        = r_mem_wdata;
    assign o_dbg_state      = r_state;
    assign o_dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change 1 ns after each rising edge
// and registered outputs are sampled at the same point. Expected read data is
// queued when a transaction is launched and popped when its ready pulse shows.
module tb_mem_arbiter;

    localparam int XLEN = 32;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BIF  = 2'd1;
    localparam logic [1:0] ST_BD   = 2'd2;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_req;
    logic [31:0]     if_addr;
    logic            if_ready;
    logic [XLEN-1:0] if_rdata;
    logic            d_req;
    logic            d_we;
    logic [3:0]      d_amp;
    logic [31:0]     d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_ready;
    logic [XLEN-1:0] d_rdata;
    logic            mem_req;
    logic            mem_we;
    logic [3:0]      mem_amp;
    logic [31:0]     mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic [1:0]      dbg_state;
    logic [2:0]      dbg_starve;

    int n_checks = 0;
    int n_pass   = 0;
    logic [XLEN-1:0] exp_if_q[$];
    logic [XLEN-1:0] exp_d_q[$];
    logic [XLEN-1:0] last_d_load;

    mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_ready         (if_ready),
        .if_rdata         (if_rdata),
        .d_req            (d_req),
        .d_we             (d_we),
        .d_amp            (d_amp),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_ready          (d_ready),
        .d_rdata          (d_rdata),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_amp          (mem_amp),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .o_dbg_state      (dbg_state),
        .o_dbg_starve_cnt (dbg_starve)
    );

    // Clock and run-time guard.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    task automatic sb_pop_if(input string tag);
        check({tag, "_pending"}, 32'(exp_if_q.size() != 0), 32'd1);
        if (exp_if_q.size() != 0) check(tag, if_rdata, exp_if_q.pop_front());
    endtask

    task automatic sb_pop_d(input string tag);
        check({tag, "_pending"}, 32'(exp_d_q.size() != 0), 32'd1);
        if (exp_d_q.size() != 0) check(tag, d_rdata, exp_d_q.pop_front());
    endtask

    task automatic drive_quiet();
        if_req    = 1'b0;
        if_addr   = 32'd0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_amp     = 4'b0000;
        d_addr    = 32'd0;
        d_wdata   = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        drive_quiet();
        last_d_load = '0;

        // Reset state.
        reset = 1'b0;
        tick();
        tick();
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_ctl", 32'({mem_we, mem_amp}), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_readies", 32'({if_ready, d_ready}), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_starve", 32'(dbg_starve), 32'd0);
        reset = 1'b1;
        tick();

        // Zero-wait fetch: ready two cycles after the request.
        if_req  = 1'b1;
        if_addr = 32'h0000_0004;
        tick();
        check("f0_mem_req", 32'(mem_req), 32'd1);
        check("f0_mem_addr", mem_addr, 32'h0000_0004);
        check("f0_mem_ctl", 32'({mem_we, mem_amp}), 32'd0);
        check("f0_state", 32'(dbg_state), 32'(ST_BIF));
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0013;
        exp_if_q.push_back(32'h0000_0013);
        tick();
        mem_ack = 1'b0;
        if_req  = 1'b0;
        check("f0_if_ready", 32'(if_ready), 32'd1);
        check("f0_mem_req_off", 32'(mem_req), 32'd0);
        sb_pop_if("f0_if_rdata");
        tick();
        check("f0_pulse_end", 32'(if_ready), 32'd0);
        check("f0_rdata_held", if_rdata, 32'h0000_0013);

        // Simultaneous fetch and load: data first, fetch granted in d_ready cycle.
        if_req  = 1'b1;
        if_addr = 32'h0000_0008;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_0100;
        tick();
        check("tie_mem_addr", mem_addr, 32'h0000_0100);
        check("tie_state", 32'(dbg_state), 32'(ST_BD));
        check("tie_starve", 32'(dbg_starve), 32'd1);
        mem_ack     = 1'b1;
        mem_rdata   = 32'hCAFE_0001;
        last_d_load = 32'hCAFE_0001;
        exp_d_q.push_back(32'hCAFE_0001);
        tick();
        mem_ack = 1'b0;
        d_req   = 1'b0;
        check("tie_d_ready", 32'({if_ready, d_ready}), 32'd1);
        check("tie_idle", 32'({dbg_state, mem_req}), 32'd0);
        sb_pop_d("tie_d_rdata");
        tick();
        check("tie_f_mem_req", 32'(mem_req), 32'd1);
        check("tie_f_mem_addr", mem_addr, 32'h0000_0008);
        check("tie_f_starve", 32'(dbg_starve), 32'd0);
        check("tie_d_pulse_end", 32'(d_ready), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0093;
        exp_if_q.push_back(32'h0000_0093);
        tick();
        mem_ack = 1'b0;
        if_req  = 1'b0;
        check("tie_if_ready", 32'({if_ready, d_ready}), 32'd2);
        sb_pop_if("tie_if_rdata");
        tick();

        // Store with three wait cycles: payload stable, d_rdata untouched.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_amp   = 4'b0011;
        d_addr  = 32'h0000_0200;
        d_wdata = 32'hDEAD_BEEF;
        exp_d_q.push_back(last_d_load);
        tick();
        for (int w = 0; w < 4; w++) begin
            check("st_mem_req", 32'(mem_req), 32'd1);
            check("st_mem_ctl", 32'({mem_we, mem_amp}), 32'h13);
            check("st_mem_addr", mem_addr, 32'h0000_0200);
            check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("st_no_ready", 32'(d_ready), 32'd0);
            if (w == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h0BAD_F00D;
            end
            tick();
        end
        mem_ack = 1'b0;
        d_req   = 1'b0;
        check("st_d_ready", 32'(d_ready), 32'd1);
        sb_pop_d("st_d_rdata");
        tick();
        check("st_pulse_end", 32'(d_ready), 32'd0);

        // Starvation: the fetch requester stands aside while each data ready
        // pulse is up, so every arbitration is a tie until the limit is hit.
        for (int g = 0; g < 5; g++) begin
            d_req   = 1'b1;
            d_we    = 1'b1;
            d_amp   = 4'b1111;
            d_addr  = 32'h0000_0300 + 32'(g * 4);
            d_wdata = 32'h0000_1000 + 32'(g);
            if_req  = 1'b1;
            if_addr = 32'h0000_0040;
            tick();
            if (g < 4) begin
                check("sv_d_grant", mem_addr, 32'h0000_0300 + 32'(g * 4));
                check("sv_cnt", 32'(dbg_starve), 32'(g + 1));
                exp_d_q.push_back(last_d_load);
                mem_rdata = 32'hFFFF_FFFF;
            end else begin
                check("sv_f_grant", 32'({mem_we, mem_amp}), 32'd0);
                check("sv_f_addr", mem_addr, 32'h0000_0040);
                check("sv_cnt_clr", 32'(dbg_starve), 32'd0);
                exp_if_q.push_back(32'h0000_0073);
                mem_rdata = 32'h0000_0073;
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            if_req  = 1'b0;
            if (g < 4) begin
                check("sv_d_ready", 32'({if_ready, d_ready}), 32'd1);
                sb_pop_d("sv_d_rdata");
            end else begin
                check("sv_if_ready", 32'({if_ready, d_ready}), 32'd2);
                sb_pop_if("sv_if_rdata");
                d_req = 1'b0;
            end
            tick();
        end

        // Reset while a load waits for its ack; a late ack is then ignored.
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0400;
        tick();
        check("rb_busy", 32'({dbg_state, mem_req}), 32'({ST_BD, 1'b1}));
        reset = 1'b0;
        tick();
        check("rb_mem_req", 32'(mem_req), 32'd0);
        check("rb_no_ready", 32'({if_ready, d_ready}), 32'd0);
        check("rb_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rb_d_rdata", d_rdata, 32'd0);
        reset = 1'b1;
        d_req = 1'b0;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("ia_no_ready", 32'({if_ready, d_ready}), 32'd0);
            check("ia_idle", 32'({dbg_state, mem_req}), 32'd0);
            check("ia_d_rdata", d_rdata, 32'd0);
            check("ia_if_rdata", if_rdata, 32'd0);
        end
        mem_ack = 1'b0;
        tick();

        check("sb_if_drained", 32'(exp_if_q.size()), 32'd0);
        check("sb_d_drained", 32'(exp_d_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter
Interface
REQ-001 SHALL provide parameter XLEN, default 32, data word width.
REQ-002 SHALL provide parameter STARVE_LIMIT, default 4, max consecutive data grants while a fetch waits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port if_req  input  1  fetch request; held with if_addr stable until if_ready.
REQ-006 SHALL have port if_addr  input  32  fetch word address.
REQ-007 SHALL have port if_ready  output  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-008 SHALL have port if_rdata  output  XLEN  fetched instruction; held until next fetch completion.
REQ-009 SHALL have port d_req  input  1  data request; held with payload stable until d_ready.
REQ-010 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port d_amp  input  4  byte enables for store.
REQ-012 SHALL have port d_addr  input  32  data address.
REQ-013 SHALL have port d_wdata  input  XLEN  store data.
REQ-014 SHALL have port d_ready  output  1  one-cycle pulse: data access complete.
REQ-015 SHALL have port d_rdata  output  XLEN  load data; unchanged by stores; held until next load completion.
REQ-016 SHALL have port mem_req  output  1  registered request to shared single-port memory.
REQ-017 SHALL have port mem_we, mem_amp(4), mem_addr(32), mem_wdata(XLEN)  output  registered payload, stable while mem_req=1.
REQ-018 SHALL have port mem_ack  input  1  memory completion; mem_rdata valid in same cycle.
REQ-019 SHALL have port mem_rdata  input  XLEN  memory read data.
Function
REQ-020 SHALL implement FSM states IDLE, BUSY_IF, BUSY_D.
REQ-021 In IDLE a port SHALL be eligible when its req=1 and its ready is not asserted in that cycle (no re-grant of a stale request).
REQ-022 Both eligible: data port SHALL win unless starve_cnt == STARVE_LIMIT, then fetch SHALL win.
REQ-023 On grant at edge t, SHALL latch payload into mem_* registers, set mem_req=1 from cycle t+1, enter BUSY_IF/BUSY_D; fetch grant drives mem_we=0, mem_amp=4'b0000, mem_wdata=0.
REQ-024 In BUSY_x, mem_req and payload SHALL stay constant until a cycle with mem_ack=1.
REQ-025 On mem_ack in BUSY_x: next cycle mem_req=0, state IDLE, x_ready=1 for exactly one cycle, x_rdata=captured mem_rdata (BUSY_D with d_we=1: d_rdata unchanged).
REQ-026 Minimum latency SHALL be 2 cycles req->ready (zero-wait memory); each extra ack wait cycle adds one.
REQ-027 In the IDLE cycle where x_ready=1, the other port SHALL be grantable; back-to-back alternating traffic SHALL incur no idle cycle.
REQ-028 mem_ack in IDLE SHALL be ignored (no ready, no state change).
REQ-029 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment on a data grant with if_req=1, clear on a data grant with if_req=0 or any fetch grant, and saturate at STARVE_LIMIT.
REQ-030 Requests dropped before ready (protocol violation) SHALL not abort an in-flight memory access; completion pulse still issues.
REQ-031 Only one of if_ready, d_ready SHALL be 1 in any cycle; mem_req SHALL never be 1 in IDLE.
Reset
REQ-032 While reset=0 at an edge: state IDLE, mem_req=0, mem_we=0, mem_amp=0, mem_addr=0, mem_wdata=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, starve_cnt=0.
REQ-033 Reset mid-transaction SHALL abandon it: no ready pulse issued; a mem_ack arriving after reset release is ignored.
Verification
REQ-034 if_req=1, if_addr=0x0000_0004, mem_ack same cycle as first mem_req, mem_rdata=0x0000_0013 -> if_ready pulse 2 cycles after req, if_rdata=0x0000_0013.
REQ-035 if_req and d_req (load 0x100) asserted same cycle -> data granted first, fetch mem_req issued in cycle d_ready=1.
REQ-036 d_req held continuously with fresh stores, if_req=1, STARVE_LIMIT=4 -> exactly 4 data grants then fetch grant, starve_cnt back to 0.
REQ-037 store d_addr=0x200, d_amp=4'b0011, d_wdata=0xDEAD_BEEF, mem_ack after 3 wait cycles -> payload stable all 4 mem_req cycles, d_ready pulse, d_rdata unchanged.
REQ-038 reset=0 while BUSY_D with ack pending -> next cycle mem_req=0, no d_ready; later mem_ack with no request -> no outputs change.
